// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack for the 4-bit datapath.
// Supports call (push), return (pop), and load (en), with sticky overflow/underflow error.
module pc_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           d,
  input  logic                       en,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pc,
  output logic [WIDTH-1:0]           pc_inc,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    push_idx;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);
  assign top_idx  = IW'(count_q - 1'b1);
  assign push_idx = IW'(count_q);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through
    // the priority chain below can leave one unassigned and infer a latch.
    pc_d    = pc_q;
    count_d = count_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (pop) begin
      if (!is_empty) begin
        pc_d    = stack_q[top_idx];
        count_d = count_q - 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (push) begin
      if (!is_full) begin
        stack_d[push_idx] = pc_inc;
        pc_d              = d;
        count_d           = count_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      pc_d = d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (!reset) begin
      pc_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      // NOTE: the stack array is cleared on reset too, so no stale return
      // address survives a reset even though top is masked while empty.
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign pc     = pc_q;
  assign pc_inc = pc_q + WIDTH'(1);
  assign top    = is_empty ? '0 : stack_q[top_idx];
  assign count  = count_q;
  assign empty  = is_empty;
  assign full   = is_full;
  assign err    = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: a queue-based reference model compared every
// cycle, plus hand-computed literal expectations from directed scenarios.
module tb_pc_stack;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d;
  logic       en, push, pop;
  logic [3:0] pc, pc_inc, top;
  logic [2:0] count;
  logic       empty, full, err;

  int checks = 0;
  int errors = 0;

  // Reference model: pc as an integer, stack as a queue (back = top).
  int         pc_m;
  logic [3:0] stack_m [$];
  logic       err_m;
  logic       model_valid = 1'b0;

  pc_stack #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .d(d), .en(en), .push(push), .pop(pop),
    .pc(pc), .pc_inc(pc_inc), .top(top), .count(count),
    .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_update();
    if (!reset) begin
      pc_m = 0;
      stack_m.delete();
      err_m = 1'b0;
    end else if (pop) begin
      if (stack_m.size() > 0) pc_m = int'(stack_m.pop_back());
      else err_m = 1'b1;
    end else if (push) begin
      if (stack_m.size() < 4) begin
        stack_m.push_back(4'((pc_m + 1) % 16));
        pc_m = int'(d);
      end else begin
        err_m = 1'b1;
      end
    end else if (en) begin
      pc_m = int'(d);
    end
  endtask

  task automatic step(input logic r, input logic po, input logic pu, input logic e,
                      input logic [3:0] dv);
    reset = r; pop = po; push = pu; en = e; d = dv;
    @(posedge clk);
    model_update();
    model_valid = 1'b1;
    #1;
  endtask

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("pc",     8'(pc),     8'(pc_m));
      check("pc_inc", 8'(pc_inc), 8'((pc_m + 1) % 16));
      check("top",    8'(top),    (stack_m.size() > 0) ? 8'(stack_m[$]) : 8'h00);
      check("count",  8'(count),  8'(stack_m.size()));
      check("empty",  8'(empty),  8'(stack_m.size() == 0));
      check("full",   8'(full),   8'(stack_m.size() == 4));
      check("err",    8'(err),    8'(err_m));
    end
  end

  initial begin
    reset = 1'b0; pop = 1'b0; push = 1'b0; en = 1'b0; d = 4'h0;

    // 1: reset dominates all commands
    step(0, 1, 1, 1, 4'h5);
    step(0, 1, 1, 1, 4'h5);
    check("rst_pc", 8'(pc), 8'h0);
    check("rst_pc_inc", 8'(pc_inc), 8'h1);
    check("rst_count", 8'(count), 8'h0);
    check("rst_empty", 8'(empty), 8'h1);
    check("rst_err", 8'(err), 8'h0);
    check("rst_top", 8'(top), 8'h0);

    // 2: sequential stepping with wrap
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 1, 4'((i + 1) % 16));
      if (i == 14) check("seq_pc_F", 8'(pc), 8'h0F);
    end
    check("seq_wrap_pc", 8'(pc), 8'h0);
    check("seq_count", 8'(count), 8'h0);

    // 3: call / return
    step(1, 0, 0, 1, 4'h3);
    step(1, 0, 1, 0, 4'hA);
    check("call_pc", 8'(pc), 8'h0A);
    check("call_top", 8'(top), 8'h04);
    check("call_count", 8'(count), 8'h1);
    step(1, 1, 0, 0, 4'h0);
    check("ret_pc", 8'(pc), 8'h04);
    check("ret_empty", 8'(empty), 8'h1);

    // 4: overflow then LIFO unwind
    step(1, 0, 0, 1, 4'h0);
    for (int i = 1; i <= 4; i++) step(1, 0, 1, 0, 4'(i));
    check("ovf_full", 8'(full), 8'h1);
    check("ovf_count", 8'(count), 8'h4);
    check("ovf_err_before", 8'(err), 8'h0);
    step(1, 0, 1, 1, 4'h9);
    check("ovf_pc", 8'(pc), 8'h04);
    check("ovf_err", 8'(err), 8'h1);
    for (int i = 4; i >= 1; i--) begin
      step(1, 1, 0, 0, 4'h0);
      check("unwind_pc", 8'(pc), 8'(i));
    end

    // 5: underflow and pop-over-push priority
    step(0, 0, 0, 0, 4'h0);
    check("rst2_err", 8'(err), 8'h0);
    step(1, 1, 1, 1, 4'h7);
    check("udf_pc", 8'(pc), 8'h0);
    check("udf_err", 8'(err), 8'h1);
    check("udf_count", 8'(count), 8'h0);
    step(1, 0, 1, 0, 4'h5);
    step(1, 1, 1, 1, 4'h8);
    check("prio_pc", 8'(pc), 8'h01);
    check("prio_count", 8'(count), 8'h0);
    check("sticky_err", 8'(err), 8'h1);

    // 6: wrapped return address and mid-sequence reset
    step(1, 0, 0, 1, 4'hF);
    step(1, 0, 1, 0, 4'h2);
    check("wrap_top", 8'(top), 8'h0);
    check("wrap_pc", 8'(pc), 8'h2);
    step(1, 1, 0, 0, 4'h0);
    check("wrap_ret_pc", 8'(pc), 8'h0);
    step(1, 0, 1, 0, 4'h1);
    step(1, 0, 1, 0, 4'h2);
    step(1, 0, 1, 0, 4'h3);
    check("mid_count", 8'(count), 8'h3);
    step(0, 0, 1, 1, 4'hC);
    check("mid_rst_pc", 8'(pc), 8'h0);
    check("mid_rst_count", 8'(count), 8'h0);
    check("mid_rst_top", 8'(top), 8'h0);
    check("mid_rst_err", 8'(err), 8'h0);
    check("mid_rst_pc_inc", 8'(pc_inc), 8'h1);
    step(1, 0, 0, 0, 4'h0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
